// File: rtl/shared_arb_pkg.sv
// Shared types and constants for the round-robin shared-register write arbiter.
package shared_arb_pkg;

  typedef enum logic {IDLE, OWNED} arb_state_t;

  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_WIDTH = 8;

  function automatic int unsigned owner_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_OWNER_W = owner_width(DEF_N_REQ);

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick
  import shared_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned OW    = owner_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [OW-1:0]    idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = (32'(ptr) + i) % N_REQ;
      if (!found && req[OW'(j)]) begin
        found          = 1'b1;
        pick[OW'(j)]   = 1'b1;
        idx            = OW'(j);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sequencing writes from N_REQ requesters into one shared register.
// Optional beat limit with forced release: define SHARED_ARB_TIMEOUT_EN.
module shared_reg_arbiter
  import shared_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = DEF_N_REQ,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         last,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     preempt
);

  localparam int unsigned OW = owner_width(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || MAX_BEATS < 1) begin : g_param_check
    $error("shared_reg_arbiter: unsupported N_REQ or MAX_BEATS");
  end

  arb_state_t       state, state_nxt;
  logic [OW-1:0]    ptr, ptr_nxt, owner_nxt, pick_idx, ptr_adv;
  logic [N_REQ-1:0] pick, gnt_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             busy_nxt, preempt_nxt;
  logic             beat, release_now, limit_hit;
  logic [WIDTH-1:0] wd [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign wd[g] = wdata[g*WIDTH +: WIDTH];
  end

  rr_pick #(.N_REQ(N_REQ), .OW(OW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign beat    = (state == OWNED) && req[owner];
  assign ptr_adv = (owner == OW'(N_REQ - 1)) ? '0 : owner + OW'(1);

`ifdef SHARED_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);
  logic [CW-1:0] beats;

  // Cleared throughout IDLE, so every grant starts counting from zero.
  always_ff @(posedge clk) begin
    if (reset)
      beats <= '0;
    else if (state == IDLE)
      beats <= '0;
    else if (beat)
      beats <= beats + CW'(1);
  end

  assign limit_hit = beat && !last[owner] && (beats == CW'(MAX_BEATS - 1));
`else
  assign limit_hit = 1'b0;
`endif

  assign release_now = (state == OWNED) &&
                       (!req[owner] || (beat && last[owner]) || limit_hit);

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    busy_nxt    = busy;
    owner_nxt   = owner;
    ptr_nxt     = ptr;
    q_nxt       = q;
    preempt_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = OWNED;
          gnt_nxt   = pick;
          busy_nxt  = 1'b1;
          owner_nxt = pick_idx;
        end
      end
      OWNED: begin
        if (beat)
          q_nxt = wd[owner];
        if (release_now) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          busy_nxt    = 1'b0;
          ptr_nxt     = ptr_adv;
          preempt_nxt = limit_hit;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      owner   <= '0;
      ptr     <= '0;
      q       <= '0;
      preempt <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      busy    <= busy_nxt;
      owner   <= owner_nxt;
      ptr     <= ptr_nxt;
      q       <= q_nxt;
      preempt <= preempt_nxt;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, last, gnt;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   q;
  logic           busy, preempt;
  logic [1:0]     owner;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       m_busy, m_preempt;
  int       m_owner, m_ptr, m_beats;
  logic [W-1:0] m_q;

  always #5 clk = ~clk;

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .wdata(wdata),
    .gnt(gnt), .q(q), .busy(busy), .owner(owner), .preempt(preempt)
  );

  task automatic model_edge();
    bit done;
    if (reset) begin
      m_busy = 0; m_preempt = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_q = '0;
    end else begin
      m_preempt = 0;
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          if (!m_busy && req[(m_ptr + i) % N]) begin
            m_busy  = 1;
            m_owner = (m_ptr + i) % N;
            m_beats = 0;
          end
        end
      end else if (req[m_owner]) begin
        m_q = wdata[m_owner*W +: W];
        m_beats++;
        done = last[m_owner];
`ifdef SHARED_ARB_TIMEOUT_EN
        if (!done && m_beats == MB) begin
          done = 1;
          m_preempt = 1;
        end
`endif
        if (done) begin
          m_busy = 0;
          m_ptr  = (m_owner + 1) % N;
        end
      end else begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      req = N'($urandom); last = N'($urandom); wdata = $urandom;
      step();
    end
    checks++; if (gnt !== '0)      begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (q !== 8'h00)     begin errors++; $display("FAIL reset_q: got %h expected 00", q); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (owner !== 2'd0)  begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt: got %b expected 0", preempt); end
    reset = 1'b0; req = '0; last = '0;
    step();
    checks++; if (gnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got gnt=%b busy=%b expected 0000/0", gnt, busy); end
  endtask

  task automatic test_single_burst();
    int gcount = 0;
    req = 4'b0001; last = '0; wdata = '0; wdata[7:0] = 8'h11;
    step(); if (gnt === 4'b0001) gcount++;
    checks++; if (gnt !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1 || q !== 8'h00)
      begin errors++; $display("FAIL burst_grant: got gnt=%b owner=%0d busy=%b q=%h expected 0001/0/1/00", gnt, owner, busy, q); end
    step(); if (gnt === 4'b0001) gcount++;
    checks++; if (q !== 8'h11) begin errors++; $display("FAIL burst_beat1: got %h expected 11", q); end
    wdata[7:0] = 8'h22;
    step(); if (gnt === 4'b0001) gcount++;
    checks++; if (q !== 8'h22) begin errors++; $display("FAIL burst_beat2: got %h expected 22", q); end
    wdata[7:0] = 8'h5A; last = 4'b0001;
    step(); if (gnt === 4'b0001) gcount++;
    checks++; if (q !== 8'h5A || gnt !== '0 || busy !== 1'b0)
      begin errors++; $display("FAIL burst_last: got q=%h gnt=%b busy=%b expected 5a/0000/0", q, gnt, busy); end
    checks++; if (gcount != 3) begin errors++; $display("FAIL burst_gnt_cycles: got %0d expected 3", gcount); end
    req = '0; last = '0; wdata[7:0] = 8'hFF;
    step();
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL burst_q_hold: got %h expected 5a", q); end
  endtask

  task automatic test_contention();
    reset = 1'b1; step(); reset = 1'b0;
    req = '1; last = '1;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'(8'hA0 + i);
    for (int k = 0; k < N; k++) begin
      step();
      checks++; if (gnt !== N'(1 << k) || owner !== 2'(k))
        begin errors++; $display("FAIL contention_grant%0d: got gnt=%b owner=%0d expected %b/%0d", k, gnt, owner, N'(1 << k), k); end
      step();
      checks++; if (q !== 8'(8'hA0 + k) || gnt !== '0)
        begin errors++; $display("FAIL contention_write%0d: got q=%h gnt=%b expected %h/0000", k, q, gnt, 8'(8'hA0 + k)); end
    end
    req = '0; last = '0;
    step();
  endtask

  task automatic test_fairness();
    req = 4'b0010; last = '0;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL fair_grant1: got %b expected 0010", gnt); end
    req = 4'b0111; last = 4'b0010;
    step();
    step();
    checks++; if (gnt !== 4'b0100 || owner !== 2'd2) begin errors++; $display("FAIL fair_next2: got gnt=%b owner=%0d expected 0100/2", gnt, owner); end
    last = 4'b0100;
    step();
    step();
    checks++; if (gnt !== 4'b0001 || owner !== 2'd0) begin errors++; $display("FAIL fair_next0: got gnt=%b owner=%0d expected 0001/0", gnt, owner); end
    req = '0; last = '0;
    step(); step();
  endtask

`ifdef SHARED_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int pcount = 0;
    req = 4'b1000; last = '0;
    step();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL timeout_grant: got %b expected 1000", gnt); end
    for (int b = 1; b <= 5; b++) begin
      wdata[3*W +: W] = 8'(b);
      step();
      if (preempt === 1'b1) pcount++;
      if (b == 4) begin
        checks++; if (gnt !== '0 || preempt !== 1'b1 || q !== 8'h04)
          begin errors++; $display("FAIL timeout_release: got gnt=%b preempt=%b q=%h expected 0000/1/04", gnt, preempt, q); end
      end
    end
    checks++; if (pcount != 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", pcount); end
    req = '0;
    step(); step();
  endtask
`else
  task automatic test_no_timeout();
    req = 4'b1000; last = '0;
    step();
    for (int b = 1; b <= 6; b++) begin
      wdata[3*W +: W] = 8'(b);
      step();
    end
    checks++; if (gnt !== 4'b1000 || preempt !== 1'b0 || q !== 8'h06)
      begin errors++; $display("FAIL no_timeout: got gnt=%b preempt=%b q=%h expected 1000/0/06", gnt, preempt, q); end
    req = '0;
    step(); step();
  endtask
`endif

  task automatic test_reset_mid_burst();
    req = 4'b0100; last = '0;
    step();
    checks++; if (gnt !== 4'b0100 || owner !== 2'd2) begin errors++; $display("FAIL midrst_grant: got gnt=%b owner=%0d expected 0100/2", gnt, owner); end
    wdata[2*W +: W] = 8'h33;
    step();
    checks++; if (q !== 8'h33) begin errors++; $display("FAIL midrst_beat1: got %h expected 33", q); end
    wdata[2*W +: W] = 8'h44; reset = 1'b1;
    step();
    checks++; if (gnt !== '0 || q !== 8'h00 || owner !== 2'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL midrst_clear: got gnt=%b q=%h owner=%0d busy=%b expected 0000/00/0/0", gnt, q, owner, busy); end
    reset = 1'b0;
    step();
    checks++; if (gnt !== 4'b0100 || owner !== 2'd2) begin errors++; $display("FAIL midrst_regrant: got gnt=%b owner=%0d expected 0100/2", gnt, owner); end
    req = '0;
    step(); step();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_gnt;
    reset = 1'b1; step(); reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      req   = N'($urandom) | N'($urandom);
      last  = N'($urandom) & N'($urandom);
      wdata = $urandom;
      step();
      exp_gnt = m_busy ? N'(1 << m_owner) : '0;
      checks++;
      if (gnt !== exp_gnt || q !== m_q || busy !== m_busy || owner !== 2'(m_owner) || preempt !== m_preempt) begin
        errors++;
        $display("FAIL random_c%0d: got gnt=%b q=%h busy=%b owner=%0d preempt=%b expected %b/%h/%b/%0d/%b",
                 c, gnt, q, busy, owner, preempt, exp_gnt, m_q, m_busy, m_owner, m_preempt);
      end
    end
    reset = 1'b0; req = '0; last = '0;
    step(); step();
  endtask

  initial begin
    reset = 1'b1; req = '0; last = '0; wdata = '0;
    test_reset();
    test_single_burst();
    test_contention();
    test_fairness();
`ifdef SHARED_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
